_latch32ton: RTL and testbench
==============================

# _latch32toN

Write-side counterpart of the 32-bit N-way bus selector. It takes one 32-bit bus word plus a binary destination address and loads it, byte-lane-wise, into one of N 32-bit holding registers. All N registers are exposed as one flattened vector, which can feed an N-way selector directly. A one-hot load strobe models the decoder-plus-octal-register discrete write path, and a valid/ready handshake sequences each write through decode and load phases.

## Interface
- N, default 8: number of 32-bit registers; legal 2..32.
- AW, localparam = $clog2(N): address width.
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: write request present.
- in_ready  output  1: block accepts a request this cycle.
- in_addr  input  AW: destination register index.
- in_data  input  32: bus word.
- in_be  input  4: byte-lane enables; bit j governs bits j*8+7:j*8.
- sel  output  N: one-hot load strobe, high only during the WRITE cycle.
- q  output  32*N: register i occupies q[i*32+31:i*32].
- done  output  1: one-cycle pulse after a write completes.
- err  output  1: one-cycle pulse, coincident with done, when in_addr >= N.

## Operation
- States: IDLE, DECODE, WRITE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture addr, data and be into holding registers, then go to DECODE.
- DECODE:
  - in_ready = 0.
  - Register the one-hot decode of the held addr into sel_q.
  - If addr >= N, sel_q = 0 and an error flag is latched.
  - Go to WRITE.
- WRITE:
  - in_ready = 0; sel = sel_q.
  - At the cycle's end edge, register i loads byte lane j from held data iff sel_q[i] & be[j]. Unselected lanes and registers hold their value.
  - Go to IDLE.
  - done is registered high for the following cycle; err is registered high with it if the error flag is set.
- be = 0: no bytes change, but done still pulses and err stays low.
- in_valid while in_ready = 0 is ignored; the request is not queued, and the requester must hold it.
- Held request registers update only on handshake. in_data and in_addr changes after acceptance have no effect.
- Reset, including mid-operation:
  - State goes to IDLE; all q go to 0; sel, done and err go to 0.
  - Any in-flight write is dropped with no partial byte update.
  - in_ready = 1 during and after reset.

## Timing
- Handshake at edge E0; DECODE during E0..E1; WRITE during E1..E2.
- q updates at E2. done and err are high during E2..E3.
- in_ready is high again in the cycle after E2, so the next handshake can occur at E3.
- Throughput is one write per 3 cycles.
- Write latency from handshake edge to visible q is 2 edges.
- sel is asserted exactly one cycle (E1..E2) per write and is never multi-hot.

## Configuration
- LATCH32_R0_ZERO_EN:
  - Defined: register 0 is hardwired to 0.
  - A write to address 0 updates nothing; sel[0] still pulses and done pulses; err stays low.
  - q[31:0] is constant 0, including after reset.
- Undefined: register 0 is an ordinary register.

## Structure
- Package latch32_pkg holds:
  - the state enum (IDLE, DECODE, WRITE);
  - BYTE_W = 8 and LANES = 4;
  - a one-hot decode function, parameterised by N, that returns 0 for out-of-range addresses.
- Sub-module _reg32_be: one 32-bit register with a load input, a 4-bit byte enable, asynchronous active-low clear, and a reset value of 0.
  - N instances are generated inside _latch32toN.
  - Instance 0 is omitted under LATCH32_R0_ZERO_EN.

## Test plan
- Reset check (N=8): hold rst_n = 0, then release.
  - Expected: all q = 0, in_ready = 1, sel = 0, done = 0.
- Full write: addr 5, data 0xDEADBEEF, be 4'hF.
  - Expected: sel = 8'h20 for one cycle, q[191:160] = 0xDEADBEEF two edges after the handshake, one done pulse, err = 0, other registers unchanged.
- Partial write: first write addr 2, data 0x11223344, be F; then addr 2, data 0xAABBCCDD, be 4'b0101.
  - Expected: register 2 = 0x11BB33DD.
- Out-of-range write: N=6, addr 7.
  - Expected: sel stays 0, no q change, done and err pulse together.
- Busy and reset interaction:
  - Hold in_valid with a new addr during DECODE/WRITE: the second request is accepted only at E3.
  - Assert rst_n = 0 during WRITE: q = 0, no write lands, state IDLE.
- Macro test with LATCH32_R0_ZERO_EN: write 0xFFFFFFFF to addr 0.
  - Expected: q[31:0] stays 0, done pulses, err = 0.

Source files
------------

// File: rtl/latch32_pkg.sv
// Shared definitions for the 32-bit N-way write-side register bank:
// FSM state encoding, byte-lane geometry and the one-hot address decoder.
package latch32_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int REG_W  = BYTE_W * LANES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WRITE  = 2'd2
  } state_e;

  // One-hot decode of addr over n registers; out-of-range addresses decode to
  // all zeros so no register can be strobed by a bad address.
  function automatic logic [31:0] onehot_dec(input int unsigned addr,
                                             input int unsigned n);
    logic [31:0] res;
    res = '0;
    if ((addr < n) && (addr < 32)) begin
      res = 32'd1 << addr;
    end
    return res;
  endfunction

endpackage

// File: rtl/_reg32_be.sv
// One 32-bit holding register with load strobe and per-byte-lane enables.
// Asynchronous active-low clear to zero.
module _reg32_be
  import latch32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LANES-1:0]  be,
  input  logic [REG_W-1:0]  d,
  output logic [REG_W-1:0]  q
);

  // Load only the enabled byte lanes when strobed; all other lanes hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      for (int j = 0; j < LANES; j++) begin
        if (be[j]) begin
          q[j*BYTE_W +: BYTE_W] <= d[j*BYTE_W +: BYTE_W];
        end
      end
    end
  end

endmodule

// File: rtl/_latch32ton.sv
// Write-side bank of N 32-bit registers. A request (addr, data, byte enables)
// is accepted in IDLE, its address is decoded in DECODE into a one-hot load
// strobe, and the selected register's enabled lanes load at the end of WRITE.
// done (and err for an out-of-range address) pulses for one cycle afterwards.
// All registers are exposed as one flat vector, register i at q[i*32 +: 32].
//
// Build option: define LATCH32_R0_ZERO_EN to hardwire register 0 to zero
// (writes to address 0 still strobe sel[0] and pulse done, but change nothing).
module _latch32ton
  import latch32_pkg::*;
#(
  parameter int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_addr,
  input  logic [31:0]      in_data,
  input  logic [3:0]       in_be,
  output logic [N-1:0]     sel,
  output logic [32*N-1:0]  q,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

`ifdef LATCH32_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Handshake: a request transfers on a rising edge where in_valid and
  // in_ready are both high. in_ready is high only in IDLE; requests presented
  // while it is low are neither accepted nor queued, so the requester holds
  // them until a transfer edge. Held request fields change only on transfer.

  state_e              state;
  logic [AW-1:0]       addr_q;
  logic [REG_W-1:0]    data_q;
  logic [LANES-1:0]    be_q;
  logic [N-1:0]        sel_q;
  logic                err_flag;

  // Sequence each request through capture, decode and load, with registered
  // in_ready/sel/done/err so all outputs are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
      sel_q    <= '0;
      err_flag <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            addr_q   <= in_addr;
            data_q   <= in_data;
            be_q     <= in_be;
            in_ready <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          sel_q    <= N'(onehot_dec(32'(addr_q), N));
          err_flag <= (32'(addr_q) >= 32'(N));
          state    <= WRITE;
        end
        WRITE: begin
          // The selected register loads on this same edge from sel_q/be_q.
          sel_q    <= '0;
          done     <= 1'b1;
          err      <= err_flag;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          sel_q    <= '0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // sel_q is non-zero only while in WRITE, so it doubles as the load strobe.
  assign sel       = sel_q;
  assign dbg_state = state;

  for (genvar i = 0; i < N; i++) begin : g_reg
    if (R0_ZERO && (i == 0)) begin : g_zero
      assign q[i*REG_W +: REG_W] = '0;
    end else begin : g_bank
      _reg32_be u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sel_q[i]),
        .be    (be_q),
        .d     (data_q),
        .q     (q[i*REG_W +: REG_W])
      );
    end
  end

endmodule

// File: tb/tb__latch32ton.sv
// Directed bench for _latch32ton: an N=8 instance for the main behaviour and
// an N=6 instance for out-of-range addresses. Expected register contents are
// hand-computed constants held in small shadow arrays.
module tb__latch32ton;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

`ifdef LATCH32_R0_ZERO_EN
  localparam logic [31:0] R0_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] R0_EXP = 32'hFFFF_FFFF;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=8 instance ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_addr = '0;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_be = '0;
  logic [7:0]   sel;
  logic [255:0] q;
  logic         done;
  logic         err;
  logic [1:0]   dbg_state;

  _latch32ton #(.N(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_be     (in_be),
    .sel       (sel),
    .q         (q),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- N=6 instance ----------------
  logic         in_valid6 = 1'b0;
  logic         in_ready6;
  logic [2:0]   in_addr6 = '0;
  logic [31:0]  in_data6 = '0;
  logic [3:0]   in_be6 = '0;
  logic [5:0]   sel6;
  logic [191:0] q6;
  logic         done6;
  logic         err6;
  logic [1:0]   dbg_state6;

  _latch32ton #(.N(6)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .in_addr   (in_addr6),
    .in_data   (in_data6),
    .in_be     (in_be6),
    .sel       (sel6),
    .q         (q6),
    .done      (done6),
    .err       (err6),
    .dbg_state (dbg_state6)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_reg [8];
  logic [31:0] exp6 [6];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [255:0] pack8();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = exp_reg[i];
    return r;
  endfunction

  function automatic logic [255:0] pack6();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = exp6[i];
    return r;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 8; i++) exp_reg[i] = '0;
    for (int i = 0; i < 6; i++) exp6[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready8();
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready8_timeout", {255'b0, in_ready}, 256'd1);
  endtask

  task automatic wait_ready6();
    int k;
    k = 0;
    while (in_ready6 !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready6_timeout", {255'b0, in_ready6}, 256'd1);
  endtask

  // One write on the N=8 instance with cycle-by-cycle checks.
  task automatic write8(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [7:0] exp_sel, input logic [31:0] exp_word);
    exp_q.push_back(exp_word);
    wait_ready8();
    in_valid = 1'b1; in_addr = a; in_data = d; in_be = be;
    @(posedge clk); #1;                       // E0: handshake
    in_valid = 1'b0; in_data = ~d; in_addr = a + 3'd1;  // must not affect the write
    check("dec_ready", {255'b0, in_ready}, 256'd0);
    check("dec_sel", {248'b0, sel}, 256'd0);
    @(posedge clk); #1;                       // E1: WRITE cycle
    check("wr_sel", {248'b0, sel}, {248'b0, exp_sel});
    check("wr_q_hold", q, pack8());
    @(posedge clk); #1;                       // E2: q visible, done high
    exp_reg[a] = exp_q.pop_front();
    check("wr_done", {255'b0, done}, 256'd1);
    check("wr_err", {255'b0, err}, 256'd0);
    check("wr_sel_clr", {248'b0, sel}, 256'd0);
    check("wr_q", q, pack8());
    @(posedge clk); #1;                       // E3
    check("done_pulse", {255'b0, done}, 256'd0);
    check("ready_back", {255'b0, in_ready}, 256'd1);
  endtask

  // One write on the N=6 instance; exp_word applies only for in-range addresses.
  task automatic write6(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [5:0] exp_sel, input logic exp_err, input logic [31:0] exp_word);
    wait_ready6();
    in_valid6 = 1'b1; in_addr6 = a; in_data6 = d; in_be6 = be;
    @(posedge clk); #1;
    in_valid6 = 1'b0;
    check("n6_dec_sel", {250'b0, sel6}, 256'd0);
    @(posedge clk); #1;
    check("n6_wr_sel", {250'b0, sel6}, {250'b0, exp_sel});
    @(posedge clk); #1;
    if (!exp_err) exp6[a] = exp_word;
    check("n6_done", {255'b0, done6}, 256'd1);
    check("n6_err", {255'b0, err6}, {255'b0, exp_err});
    check("n6_q", {64'b0, q6}, pack6());
    @(posedge clk); #1;
    check("n6_done_pulse", {254'b0, done6, err6}, 256'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_models();

    // Reset state, sampled while reset is held and after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {255'b0, in_ready}, 256'd1);
    check("rst_q", q, 256'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_q_after", q, 256'd0);
    check("rst_sel", {248'b0, sel}, 256'd0);
    check("rst_done", {254'b0, done, err}, 256'd0);
    check("rst_state", {254'b0, dbg_state}, {254'b0, S_IDLE});
    check("rst_ready_after", {255'b0, in_ready}, 256'd1);

    // Full write.
    write8(3'd5, 32'hDEAD_BEEF, 4'hF, 8'h20, 32'hDEAD_BEEF);
    // Partial write on top of a full write: lanes 0 and 2 replaced.
    write8(3'd2, 32'h1122_3344, 4'hF, 8'h04, 32'h1122_3344);
    write8(3'd2, 32'hAABB_CCDD, 4'b0101, 8'h04, 32'h11BB_33DD);
    // be = 0: nothing changes but done still pulses.
    write8(3'd5, 32'h0000_0000, 4'h0, 8'h20, 32'hDEAD_BEEF);
    // Register 0 (hardwired to zero under LATCH32_R0_ZERO_EN).
    write8(3'd0, 32'hFFFF_FFFF, 4'hF, 8'h01, R0_EXP);
    // Top address and upper-lane-only write.
    write8(3'd7, 32'h0BAD_F00D, 4'hF, 8'h80, 32'h0BAD_F00D);
    write8(3'd7, 32'h1234_5678, 4'b1100, 8'h80, 32'h1234_F00D);

    // Busy interaction: second request held from E0 is taken only at E3.
    wait_ready8();
    in_valid = 1'b1; in_addr = 3'd1; in_data = 32'h0101_0101; in_be = 4'hF;
    @(posedge clk); #1;                       // E0
    in_addr = 3'd4; in_data = 32'h4444_4444;  // held, valid stays high
    check("busy_state_e0", {254'b0, dbg_state}, {254'b0, S_DECODE});
    check("busy_ready_e0", {255'b0, in_ready}, 256'd0);
    @(posedge clk); #1;                       // E1
    check("busy_sel_e1", {248'b0, sel}, 256'h02);
    check("busy_state_e1", {254'b0, dbg_state}, {254'b0, S_WRITE});
    @(posedge clk); #1;                       // E2
    exp_reg[1] = 32'h0101_0101;
    check("busy_q_e2", q, pack8());
    check("busy_done_e2", {255'b0, done}, 256'd1);
    check("busy_ready_e2", {255'b0, in_ready}, 256'd1);
    @(posedge clk); #1;                       // E3: second handshake
    in_valid = 1'b0;
    check("busy_state_e3", {254'b0, dbg_state}, {254'b0, S_DECODE});
    check("busy_done_e3", {255'b0, done}, 256'd0);
    @(posedge clk); #1;
    check("busy_sel_e4", {248'b0, sel}, 256'h10);
    @(posedge clk); #1;
    exp_reg[4] = 32'h4444_4444;
    check("busy_q_e5", q, pack8());
    check("busy_done_e5", {255'b0, done}, 256'd1);

    // Out-of-range addresses on the N=6 instance.
    write6(3'd5, 32'hCAFE_F00D, 4'hF, 6'h20, 1'b0, 32'hCAFE_F00D);
    write6(3'd7, 32'h7777_7777, 4'hF, 6'h00, 1'b1, 32'h0);
    write6(3'd6, 32'h6666_6666, 4'hF, 6'h00, 1'b1, 32'h0);
    write6(3'd2, 32'h2222_2222, 4'h0, 6'h04, 1'b0, 32'h0);

    // Reset asserted during WRITE: the write is dropped and all registers clear.
    wait_ready8();
    in_valid = 1'b1; in_addr = 3'd6; in_data = 32'h6666_6666; in_be = 4'hF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_state_write", {254'b0, dbg_state}, {254'b0, S_WRITE});
    check("mid_sel", {248'b0, sel}, 256'h40);
    rst_n = 1'b0;
    #1;
    clear_models();
    check("mid_rst_q", q, pack8());
    check("mid_rst_sel", {248'b0, sel}, 256'd0);
    check("mid_rst_ready", {255'b0, in_ready}, 256'd1);
    check("mid_rst_state", {254'b0, dbg_state}, {254'b0, S_IDLE});
    check("mid_rst_q6", {64'b0, q6}, pack6());
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_q", q, pack8());
    check("post_rst_done", {254'b0, done, err}, 256'd0);

    // Normal operation resumes after reset.
    write8(3'd3, 32'h1234_5678, 4'b1100, 8'h08, 32'h1234_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
